// File: rtl/instruction_fetcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : instruction_fetcher                                        |
// | Description : Fetch stage between the branch target buffer and          |
// |               dispatch. Takes pc_in, fetches the word from an optional   |
// |               direct-mapped icache or from the memory controller,        |
// |               pulses fetch_new_instruction to advance the predictor and  |
// |               pushes {inst, pc} into an internal circular instruction    |
// |               queue (IQ). Honours stop_fetching (JALR stall) and         |
// |               roll_back (mispredict flush).                              |
// | Macro       : ICACHE_EN - compile in the direct-mapped icache.           |
// | Ports       : clk_in, rst_in (async, active-high), rdy_in (pause)        |
// |               pc_in, stop_fetching, roll_back       - from predictor     |
// |               fetch_new_instruction, fetch_inst     - to decoder/pred.   |
// |               mem_req, mem_addr, mem_done, mem_data - memory controller  |
// |               iq_valid, iq_inst, iq_pc, iq_pop      - dispatch side      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module instruction_fetcher #(
  parameter int IQ_DEPTH    = 16,
  parameter int ICACHE_SIZE = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] pc_in,
  input  logic        stop_fetching,
  input  logic        roll_back,
  output logic        fetch_new_instruction,
  output logic [31:0] fetch_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  input  logic        iq_pop
);

  localparam int                 c_IQ_AW   = $clog2(IQ_DEPTH);
  localparam logic [c_IQ_AW:0]   c_IQ_FULL = (c_IQ_AW + 1)'(IQ_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ISSUE    = 2'd2,
    S_DRAIN    = 2'd3
  } state_t;

  state_t               r_state;
  logic [31:0]          r_pc;
  logic [31:0]          r_iq_inst_mem [IQ_DEPTH];
  logic [31:0]          r_iq_pc_mem   [IQ_DEPTH];
  logic [c_IQ_AW-1:0]   r_head;
  logic [c_IQ_AW-1:0]   r_tail;
  logic [c_IQ_AW:0]     r_count;

  logic                 w_start;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_hit;
  logic [31:0]          w_hit_data;

  // ---------------------------------------------------------------------------
  // Optional icache
  // ---------------------------------------------------------------------------
`ifdef ICACHE_EN
  localparam int c_IC_IW = $clog2(ICACHE_SIZE);
  localparam int c_IC_TW = 30 - c_IC_IW;

  logic [ICACHE_SIZE-1:0] r_ic_valid;
  logic [c_IC_TW-1:0]     r_ic_tag  [ICACHE_SIZE];
  logic [31:0]            r_ic_data [ICACHE_SIZE];

  logic [c_IC_IW-1:0]     w_ic_idx;
  logic [c_IC_TW-1:0]     w_ic_tag;
  logic [c_IC_IW-1:0]     w_fill_idx;
  logic [c_IC_TW-1:0]     w_fill_tag;
  logic                   w_fill;

  assign w_ic_idx   = pc_in[c_IC_IW+1:2];
  assign w_ic_tag   = pc_in[31:c_IC_IW+2];
  // Fills use the latched request address, which stays correct even in DRAIN.
  assign w_fill_idx = mem_addr[c_IC_IW+1:2];
  assign w_fill_tag = mem_addr[31:c_IC_IW+2];
  assign w_fill     = rdy_in && mem_done &&
                      ((r_state == S_MEM_WAIT) || (r_state == S_DRAIN));

  assign w_hit      = r_ic_valid[w_ic_idx] && (r_ic_tag[w_ic_idx] == w_ic_tag);
  assign w_hit_data = r_ic_data[w_ic_idx];

  // Valid bits are only cleared by reset; a flush leaves cached lines intact.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_ic_valid <= '0;
    end else if (w_fill) begin
      r_ic_valid[w_fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_fill) begin
      r_ic_tag[w_fill_idx]  <= w_fill_tag;
      r_ic_data[w_fill_idx] <= mem_data;
    end
  end
`else
  logic unused_icache_cfg;
  assign unused_icache_cfg = (ICACHE_SIZE == 0);
  assign w_hit             = 1'b0;
  assign w_hit_data        = '0;
`endif

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  assign w_start = (r_state == S_IDLE) && !stop_fetching && !roll_back &&
                   (r_count != c_IQ_FULL);
  // The issue pulse must react to a same-cycle roll_back or pause, so it is
  // decoded from the ISSUE state rather than registered ahead of time.
  assign w_push  = rdy_in && (r_state == S_ISSUE) && !roll_back;
  assign w_pop   = rdy_in && iq_pop && iq_valid;

  assign fetch_new_instruction = w_push;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fetch_inst <= '0;
    end else if (rdy_in) begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_pc <= pc_in;
            if (w_hit) begin
              fetch_inst <= w_hit_data;
              r_state    <= S_ISSUE;
            end else begin
              mem_addr <= pc_in;
              mem_req  <= 1'b1;
              r_state  <= S_MEM_WAIT;
            end
          end
        end
        S_MEM_WAIT: begin
          if (mem_done) begin
            mem_req <= 1'b0;
            // A flush coinciding with the response discards the word here;
            // going to DRAIN would wait for a response that has already come.
            if (roll_back) begin
              r_state <= S_IDLE;
            end else begin
              fetch_inst <= mem_data;
              r_state    <= S_ISSUE;
            end
          end else if (roll_back) begin
            r_state <= S_DRAIN;
          end
        end
        S_ISSUE: begin
          r_state <= S_IDLE;
        end
        S_DRAIN: begin
          if (mem_done) begin
            mem_req <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction queue
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (roll_back) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        // Power-of-two depth: natural pointer overflow is the wrap.
        if (w_push) r_tail <= r_tail + 1'b1;
        if (w_pop)  r_head <= r_head + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_iq_inst_mem[r_tail] <= fetch_inst;
      r_iq_pc_mem[r_tail]   <= r_pc;
    end
  end

  assign iq_valid = (r_count != '0);
  // Storage is not reset; gating keeps the head outputs at zero when empty.
  assign iq_inst  = iq_valid ? r_iq_inst_mem[r_head] : '0;
  assign iq_pc    = iq_valid ? r_iq_pc_mem[r_head]   : '0;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_instruction_fetcher                                     |
// | Description : Directed self-checking bench for instruction_fetcher.      |
// |               Inputs change 1 time unit after the rising edge, outputs   |
// |               are sampled at that point as well.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_instruction_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] pc_in;
  logic        stop_fetching;
  logic        roll_back;
  logic        fetch_new_instruction;
  logic [31:0] fetch_inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_pop;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instruction_fetcher #(
    .IQ_DEPTH    (16),
    .ICACHE_SIZE (64)
  ) dut (
    .clk_in                (clk),
    .rst_in                (rst),
    .rdy_in                (rdy),
    .pc_in                 (pc_in),
    .stop_fetching         (stop_fetching),
    .roll_back             (roll_back),
    .fetch_new_instruction (fetch_new_instruction),
    .fetch_inst            (fetch_inst),
    .mem_req               (mem_req),
    .mem_addr              (mem_addr),
    .mem_done              (mem_done),
    .mem_data              (mem_data),
    .iq_valid              (iq_valid),
    .iq_inst               (iq_inst),
    .iq_pc                 (iq_pc),
    .iq_pop                (iq_pop)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Miss fetch through memory; optional pop of the previous head on the push edge.
  task automatic fetch_mem(input logic [31:0] pc, input logic [31:0] data, input int lat,
                           input bit pop_on_push, input logic [31:0] exp_inst,
                           input logic [31:0] exp_pc);
    pc_in = pc;
    stop_fetching = 1'b0;
    tick;
    stop_fetching = 1'b1;
    chk("req_start", 32'(mem_req), 1);
    chk("req_addr", mem_addr, pc);
    chk("no_pulse_in_wait", 32'(fetch_new_instruction), 0);
    for (int k = 1; k < lat; k++) begin
      tick;
      chk("req_hold", 32'(mem_req), 1);
      chk("addr_hold", mem_addr, pc);
    end
    mem_done = 1'b1;
    mem_data = data;
    tick;
    mem_done = 1'b0;
    mem_data = '0;
    chk("issue_pulse", 32'(fetch_new_instruction), 1);
    chk("issue_inst", fetch_inst, data);
    chk("req_drop", 32'(mem_req), 0);
    if (pop_on_push) begin
      chk("pp_head_inst", iq_inst, exp_inst);
      chk("pp_head_pc", iq_pc, exp_pc);
      iq_pop = 1'b1;
    end
    tick;
    iq_pop = 1'b0;
    chk("pulse_once", 32'(fetch_new_instruction), 0);
  endtask

  task automatic pop_check(input logic [31:0] exp_inst, input logic [31:0] exp_pc);
    chk("head_valid", 32'(iq_valid), 1);
    chk("head_inst", iq_inst, exp_inst);
    chk("head_pc", iq_pc, exp_pc);
    iq_pop = 1'b1;
    tick;
    iq_pop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; pc_in = '0; stop_fetching = 1'b1; roll_back = 1'b0;
    mem_done = 1'b0; mem_data = '0; iq_pop = 1'b0;
    repeat (2) tick;

    // Reset values
    chk("rst_pulse", 32'(fetch_new_instruction), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_inst", fetch_inst, 0);
    chk("rst_iq_valid", 32'(iq_valid), 0);
    chk("rst_iq_inst", iq_inst, 0);
    chk("rst_iq_pc", iq_pc, 0);
    rst = 1'b0;

    // Reset asserted during MEM_WAIT; stale mem_done afterwards is ignored
    pc_in = 32'h0;
    stop_fetching = 1'b0;
    tick;
    stop_fetching = 1'b1;
    chk("mw_req", 32'(mem_req), 1);
    rst = 1'b1;
    mem_done = 1'b1;
    mem_data = 32'hBAD0BAD0;
    #1;
    chk("arst_req", 32'(mem_req), 0);
    chk("arst_iq_valid", 32'(iq_valid), 0);
    tick;
    rst = 1'b0;
    tick;
    mem_done = 1'b0;
    mem_data = '0;
    chk("stale_done_pulse", 32'(fetch_new_instruction), 0);
    chk("stale_done_req", 32'(mem_req), 0);
    chk("stale_done_iq", 32'(iq_valid), 0);
    fetch_mem(32'h0, 32'h00000013, 2, 1'b0, '0, '0);
    pop_check(32'h00000013, 32'h0);
    chk("empty_after_pop", 32'(iq_valid), 0);

    // Miss at 0x100 then refetch (hit when the icache is built in)
    fetch_mem(32'h100, 32'h00500093, 3, 1'b0, '0, '0);
    chk("miss_head_inst", iq_inst, 32'h00500093);
    chk("miss_head_pc", iq_pc, 32'h100);
`ifdef ICACHE_EN
    pc_in = 32'h100;
    stop_fetching = 1'b0;
    tick;
    stop_fetching = 1'b1;
    chk("hit_pulse", 32'(fetch_new_instruction), 1);
    chk("hit_no_req", 32'(mem_req), 0);
    chk("hit_inst", fetch_inst, 32'h00500093);
    tick;
`else
    fetch_mem(32'h100, 32'h00500093, 1, 1'b0, '0, '0);
`endif
    pop_check(32'h00500093, 32'h100);
    pop_check(32'h00500093, 32'h100);

    // roll_back during MEM_WAIT: drain, never issue
    pc_in = 32'h200;
    stop_fetching = 1'b0;
    tick;
    stop_fetching = 1'b1;
    chk("rb_req", 32'(mem_req), 1);
    roll_back = 1'b1;
    tick;
    roll_back = 1'b0;
    chk("drain_req", 32'(mem_req), 1);
    chk("drain_pulse", 32'(fetch_new_instruction), 0);
    tick;
    chk("drain_req2", 32'(mem_req), 1);
    chk("drain_addr", mem_addr, 32'h200);
    mem_done = 1'b1;
    mem_data = 32'hDEADBEEF;
    tick;
    mem_done = 1'b0;
    chk("drain_done_req", 32'(mem_req), 0);
    chk("drain_done_pulse", 32'(fetch_new_instruction), 0);
    tick;
    chk("drain_idle_pulse", 32'(fetch_new_instruction), 0);
    chk("drain_iq_empty", 32'(iq_valid), 0);

    // stop_fetching for 10 cycles
    pc_in = 32'h300;
    stop_fetching = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("stop_req", 32'(mem_req), 0);
      chk("stop_pulse", 32'(fetch_new_instruction), 0);
    end
    fetch_mem(32'h300, 32'h00000333, 1, 1'b0, '0, '0);
    pop_check(32'h00000333, 32'h300);

    // Fill IQ to 16 entries
    for (int i = 0; i < 16; i++)
      fetch_mem(32'h1000 + 32'(4 * i), 32'hA0000000 + 32'(i), 1, 1'b0, '0, '0);
    pc_in = 32'h2000;
    stop_fetching = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("full_req", 32'(mem_req), 0);
      chk("full_pulse", 32'(fetch_new_instruction), 0);
    end
    pop_check(32'hA0000000, 32'h1000);
    fetch_mem(32'h2000, 32'hB0000000, 1, 1'b0, '0, '0);
    pc_in = 32'h2004;
    stop_fetching = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("refull_req", 32'(mem_req), 0);
    end
    stop_fetching = 1'b1;
    for (int i = 1; i < 16; i++)
      pop_check(32'hA0000000 + 32'(i), 32'h1000 + 32'(4 * i));
    pop_check(32'hB0000000, 32'h2000);
    chk("drained_empty", 32'(iq_valid), 0);

    // 40 simultaneous push/pop pairs, pointers wrap repeatedly
    fetch_mem(32'h4000, 32'hC0000000, 1, 1'b0, '0, '0);
    for (int i = 1; i <= 40; i++)
      fetch_mem(32'h4000 + 32'(4 * i), 32'hC0000000 + 32'(i), 1, 1'b1,
                32'hC0000000 + 32'(i - 1), 32'h4000 + 32'(4 * (i - 1)));
    pop_check(32'hC0000028, 32'h40A0);
    chk("pairs_empty", 32'(iq_valid), 0);

    // roll_back coincident with ISSUE and iq_pop
    fetch_mem(32'h5000, 32'h00005000, 1, 1'b0, '0, '0);
    pc_in = 32'h5004;
    stop_fetching = 1'b0;
    tick;
    stop_fetching = 1'b1;
    mem_done = 1'b1;
    mem_data = 32'h00005004;
    tick;
    mem_done = 1'b0;
    roll_back = 1'b1;
    iq_pop = 1'b1;
    #1;
    chk("rb_issue_pulse", 32'(fetch_new_instruction), 0);
    tick;
    roll_back = 1'b0;
    iq_pop = 1'b0;
    chk("rb_issue_iq", 32'(iq_valid), 0);
    chk("rb_issue_req", 32'(mem_req), 0);
    tick;
    chk("rb_issue_iq_late", 32'(iq_valid), 0);

    // rdy_in low in ISSUE: pulse forced low, state and IQ hold
    pc_in = 32'h6000;
    stop_fetching = 1'b0;
    tick;
    stop_fetching = 1'b1;
    mem_done = 1'b1;
    mem_data = 32'h00006000;
    tick;
    mem_done = 1'b0;
    rdy = 1'b0;
    #1;
    chk("rdy_pulse_low", 32'(fetch_new_instruction), 0);
    tick;
    chk("rdy_no_push", 32'(iq_valid), 0);
    rdy = 1'b1;
    #1;
    chk("rdy_pulse_resume", 32'(fetch_new_instruction), 1);
    tick;
    pop_check(32'h00006000, 32'h6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetcher.md
# instruction_fetcher

Fetch stage between the branch target buffer and the instruction queue/dispatch. Each cycle it may take the current `pc_in` from the branch target buffer and fetch the word at that address, either from an optional direct-mapped icache or from the memory controller. It presents the word to the decoder and pulses `fetch_new_instruction` so the predictor advances its PC. It also pushes {inst, pc} into an internal instruction queue (IQ) for dispatch, and honours `stop_fetching` (JALR stall) and `roll_back` (mispredict flush).

## Interface
- `IQ_DEPTH`, default 16: IQ entries; power of two, ≥ 2.
- `ICACHE_SIZE`, default 64: icache words; power of two; used only with `ICACHE_EN`.
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, asynchronous, active-high.
- `rdy_in` in 1: pause when low.
- `pc_in` in 32: fetch address from the branch target buffer.
- `stop_fetching` in 1: JALR pending; do not start new fetches.
- `roll_back` in 1: mispredict; flush.
- `fetch_new_instruction` out 1: one-cycle pulse; `fetch_inst` is valid for `pc_in`.
- `fetch_inst` out 32: fetched word, driven to the decoder (op/imm to the predictor).
- `mem_req` out 1: memory read request.
- `mem_addr` out 32: word address of the request.
- `mem_done` in 1: one-cycle pulse; `mem_data` is valid.
- `mem_data` in 32: returned word.
- `iq_valid` out 1: IQ head valid.
- `iq_inst` out 32: IQ head instruction.
- `iq_pc` out 32: IQ head PC.
- `iq_pop` in 1: dispatch consumes the head; ignored when `!iq_valid`.

## Operation
- FSM states:
  - IDLE, MEM_WAIT, ISSUE, DRAIN.
- IDLE:
  - Start is allowed only when `!stop_fetching`, `!roll_back` and IQ count < `IQ_DEPTH`; otherwise hold.
  - Cache hit (valid and tag match): latch the word into `fetch_inst` and go to ISSUE.
  - Miss: latch `mem_addr` = `pc_in`, set `mem_req`=1, go to MEM_WAIT.
- MEM_WAIT:
  - `mem_req` and `mem_addr` are held stable.
  - On `mem_done`: drop `mem_req` next cycle, latch `mem_data` into `fetch_inst`, write the cache line, go to ISSUE.
  - On `roll_back`: go to DRAIN.
- ISSUE:
  - `fetch_new_instruction`=1 for exactly this cycle.
  - Push {`fetch_inst`, latched pc} into the IQ.
  - Return to IDLE; `pc_in` is the updated predictor PC by then.
  - If `roll_back` is high in ISSUE: pulse suppressed, no push, go IDLE.
- DRAIN:
  - Keep `mem_req` until `mem_done`.
  - The data may fill the cache (address is still correct) but is never issued.
  - Then go to IDLE.
- IQ:
  - Circular buffer with head, tail and count (width log2(`IQ_DEPTH`)+1).
  - Push and pop in the same cycle leave count unchanged; both pointers wrap modulo `IQ_DEPTH`.
  - `roll_back` clears head, tail and count the next edge, overriding a same-cycle push or pop.
- Icache:
  - index = `pc_in`[log2(`ICACHE_SIZE`)+1:2]; tag = `pc_in`[31:log2(`ICACHE_SIZE`)+2].
  - Valid bits are cleared only by reset; `roll_back` does not invalidate.
- `rdy_in` low:
  - All registers hold; no push, pop, or state change.
  - `fetch_new_instruction` is forced 0; `mem_req` is held.

## Timing
- Reset values:
  - State IDLE; all outputs 0 (`mem_addr`, `fetch_inst`, `iq_inst`, `iq_pc` = 0).
  - IQ empty; all cache valid bits 0.
- Reset mid-fetch: return to IDLE immediately and drop `mem_req`; an in-flight `mem_done` after reset is ignored.
- Hit: `pc_in` sampled in IDLE at cycle t; `fetch_new_instruction` at t+1; `iq_valid` at t+2 (if IQ was empty). Sustained hits give one instruction per 2 cycles.
- Miss: `mem_req` high from t+1; `mem_done` at d; ISSUE at d+1.
- Pop: registered; the new head is visible on the next cycle.

## Configuration
- `ICACHE_EN`:
  - Defined: the icache described above is compiled in.
  - Undefined: no cache storage; every IDLE start goes to MEM_WAIT, and DRAIN discards its data.

## Test plan
- Reset asserted mid-MEM_WAIT: `mem_req`=0, `iq_valid`=0 and state IDLE at the next edge. Re-fetch of pc=0 issues a fresh `mem_req` with `mem_addr`=0.
- `ICACHE_EN`, pc=0x100 miss, `mem_done` 3 cycles later with 0x00500093: ISSUE pulse, IQ head {0x00500093, 0x100}. A second fetch of 0x100 pulses `fetch_new_instruction` 1 cycle after IDLE with no `mem_req`.
- `roll_back` during MEM_WAIT for 0x200: no pulse, IQ empty, `mem_req` held until `mem_done`, then IDLE.
- Fill IQ to 16 with `iq_pop`=0: the FSM holds in IDLE. One pop permits exactly one more push; count wraps correctly over 40 push/pop pairs.
- `stop_fetching`=1 for 10 cycles: no `mem_req`, no pulse; fetching resumes the cycle after it falls.
- `roll_back` coincident with an ISSUE and an `iq_pop`: no pulse, count=0 next cycle.
